// File: rtl/ecc_sram_err_logger_if.sv
// TCDM request port of one ECC SRAM bank, as seen by an observer.
// The bank side drives every signal; the error logger only listens.
interface ecc_sram_err_logger_if #(
    parameter int unsigned BEWidth = 4
);
    logic               req;
    logic               gnt;
    logic               wen;
    logic [BEWidth-1:0] be;
    logic [31:0]        add;

    modport master (output req, gnt, wen, be, add);
    modport slave  (input  req, gnt, wen, be, add);
endinterface

// File: rtl/ecc_sram_err_logger.sv
// ECC SRAM bank error logger: saturating event counters, first-failing-word
// capture and a sticky interrupt, purely observing the bank's TCDM port.
module ecc_sram_err_logger #(
    parameter  int unsigned BankSize     = 256,
    parameter  int unsigned BEWidth      = 4,
    parameter  int unsigned CntWidth     = 16,
    localparam int unsigned BankAddWidth = $clog2(BankSize)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ecc_sram_err_logger_if.slave       tcdm,
    input  logic                       single_error_i,
    input  logic                       multi_error_i,
    input  logic                       scrub_fix_i,
    input  logic                       scrub_uncorrectable_i,
    input  logic                       clear_i,
    input  logic                       irq_en_i,
    output logic [CntWidth-1:0]        single_cnt_o,
    output logic [CntWidth-1:0]        multi_cnt_o,
    output logic [CntWidth-1:0]        scrub_fix_cnt_o,
    output logic [CntWidth-1:0]        scrub_unc_cnt_o,
    output logic [BankAddWidth-1:0]    err_addr_o,
    output logic                       err_valid_o,
    output logic                       err_multi_o,
    output logic                       irq_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CAP_SINGLE = 2'd1,
        CAP_MULTI  = 2'd2
    } state_e;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] cnt,
                                                    input logic                ev);
        if (ev && (cnt != {CntWidth{1'b1}})) begin
            return cnt + {{(CntWidth-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

    state_e                  state_q;
    logic                    pend_q;
    logic [BankAddWidth-1:0] addr_q;
    logic [BankAddWidth-1:0] err_addr_q;
    logic                    err_valid_q;
    logic                    err_multi_q;
    logic                    irq_q;
    logic [CntWidth-1:0]     single_cnt_q;
    logic [CntWidth-1:0]     multi_cnt_q;
    logic [CntWidth-1:0]     scrub_fix_cnt_q;
    logic [CntWidth-1:0]     scrub_unc_cnt_q;

    logic checked_s;
    logic single_ev_s;
    logic capture_s;
    logic unused_add_s;

    // Only reads and partial writes go through the ECC check path of the wrapper.
    always_comb begin
        checked_s   = tcdm.req & tcdm.gnt & (tcdm.wen | (tcdm.be != {BEWidth{1'b1}}));
        single_ev_s = single_error_i & ~multi_error_i;
        capture_s   = 1'b0;
        if (pend_q && (state_q == IDLE)) begin
            capture_s = single_error_i | multi_error_i;
        end else if (pend_q && (state_q == CAP_SINGLE)) begin
            capture_s = multi_error_i;
        end else begin
            capture_s = 1'b0;
        end
    end

    assign unused_add_s = ^{tcdm.add[31:BankAddWidth+2], tcdm.add[1:0]};

    // Remember the word of the access whose response arrives next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            addr_q <= {BankAddWidth{1'b0}};
        end else begin
            pend_q <= checked_s;
            if (checked_s) begin
                addr_q <= tcdm.add[BankAddWidth+1:2];
            end else begin
                addr_q <= addr_q;
            end
        end
    end

    // Saturating event counters; a simultaneous single and multi counts as multi.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            single_cnt_q    <= {CntWidth{1'b0}};
            multi_cnt_q     <= {CntWidth{1'b0}};
            scrub_fix_cnt_q <= {CntWidth{1'b0}};
            scrub_unc_cnt_q <= {CntWidth{1'b0}};
        end else if (clear_i) begin
            single_cnt_q    <= {CntWidth{1'b0}};
            multi_cnt_q     <= {CntWidth{1'b0}};
            scrub_fix_cnt_q <= {CntWidth{1'b0}};
            scrub_unc_cnt_q <= {CntWidth{1'b0}};
        end else begin
            single_cnt_q    <= sat_inc(single_cnt_q, single_ev_s);
            multi_cnt_q     <= sat_inc(multi_cnt_q, multi_error_i);
            scrub_fix_cnt_q <= sat_inc(scrub_fix_cnt_q, scrub_fix_i);
            scrub_unc_cnt_q <= sat_inc(scrub_unc_cnt_q, scrub_uncorrectable_i);
        end
    end

    // Capture FSM with its registered outputs and the sticky interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            err_addr_q  <= {BankAddWidth{1'b0}};
            err_valid_q <= 1'b0;
            err_multi_q <= 1'b0;
            irq_q       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            err_addr_q  <= {BankAddWidth{1'b0}};
            err_valid_q <= 1'b0;
            err_multi_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, CAP_SINGLE: begin
                    if (pend_q && multi_error_i) begin
                        state_q     <= CAP_MULTI;
                        err_addr_q  <= addr_q;
                        err_valid_q <= 1'b1;
                        err_multi_q <= 1'b1;
                    end else if (pend_q && single_error_i && (state_q == IDLE)) begin
                        state_q     <= CAP_SINGLE;
                        err_addr_q  <= addr_q;
                        err_valid_q <= 1'b1;
                        err_multi_q <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                CAP_MULTI: begin
                    state_q <= CAP_MULTI;
                end
                default: begin
                    state_q     <= IDLE;
                    err_addr_q  <= {BankAddWidth{1'b0}};
                    err_valid_q <= 1'b0;
                    err_multi_q <= 1'b0;
                end
            endcase
            if (irq_en_i && (capture_s || scrub_uncorrectable_i)) begin
                irq_q <= 1'b1;
            end else begin
                irq_q <= irq_q;
            end
        end
    end

    assign single_cnt_o    = single_cnt_q;
    assign multi_cnt_o     = multi_cnt_q;
    assign scrub_fix_cnt_o = scrub_fix_cnt_q;
    assign scrub_unc_cnt_o = scrub_unc_cnt_q;
    assign err_addr_o      = err_addr_q;
    assign err_valid_o     = err_valid_q;
    assign err_multi_o     = err_multi_q;
    assign irq_o           = irq_q;

endmodule
